// File: rtl/sa_out_deskew_8bit_if.sv
// Row-drain handshake between the deskew buffer and the next stage.
// The deskew block drives the row (master); the consumer answers with ready (slave).
interface sa_out_deskew_8bit_if #(
  parameter int IDX_W = 6
);
  logic             O_ROW_VLD;
  logic             I_ROW_RDY;
  logic [511:0]     O_ROW;
  logic [IDX_W-1:0] O_ROW_IDX;
  logic             O_LAST;

  modport master (
    output O_ROW_VLD,
    output O_ROW,
    output O_ROW_IDX,
    output O_LAST,
    input  I_ROW_RDY
  );

  modport slave (
    input  O_ROW_VLD,
    input  O_ROW,
    input  O_ROW_IDX,
    input  O_LAST,
    output I_ROW_RDY
  );
endinterface

// File: rtl/sa_out_deskew_8bit.sv
// Rebuilds row-major result rows from the skewed systolic-array output bus
// and drains them one row per handshake to the next stage.
module sa_out_deskew_8bit #(
  parameter int X_R = 64,
  parameter int LAT = 66
) (
  input  logic                          I_CLK,
  input  logic                          I_RST_N,
  input  logic                          I_START_FLAG,
  input  logic [511:0]                  I_SA_OUT,
  sa_out_deskew_8bit_if.master          rowIf,
  output logic                          O_BUSY,
  output logic                          O_DONE
);

  localparam int CW     = $clog2(LAT + X_R + 64);
  localparam int IW     = (X_R > 1) ? $clog2(X_R) : 1;
  localparam int NCOL   = 64;
  localparam logic [CW-1:0] LAST_T  = CW'(LAT + X_R + 62);
  localparam logic [IW-1:0] LAST_ROW = IW'(X_R - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            done_q, done_d;

  logic [7:0]      rowBuf_q [X_R][NCOL];

  logic            capturing;
  logic [NCOL-1:0] colWrEn;
  logic [IW-1:0]   colRow [NCOL];
  logic            lastRow;
  logic            xfer;

  assign lastRow = (ptr_q == LAST_ROW);
  assign xfer    = (state_q == DRAIN) && rowIf.I_ROW_RDY;

  // A start pulse restarts the timeline, so the old run stops writing on that cycle.
  assign capturing = (state_q == CAPTURE) && !I_START_FLAG;

  always_comb begin
    colWrEn = '0;
    for (int c = 0; c < NCOL; c++) begin
      colRow[c]  = IW'(cnt_q - CW'(LAT + c));
      colWrEn[c] = capturing &&
                   (cnt_q >= CW'(LAT + c)) &&
                   (cnt_q <  CW'(LAT + c + X_R));
    end
  end

  always_ff @(posedge I_CLK) begin
    for (int c = 0; c < NCOL; c++) begin
      if (colWrEn[c]) begin
        rowBuf_q[colRow[c]][c] <= I_SA_OUT[c*8 +: 8];
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        ptr_d = '0;
      end
      CAPTURE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_T) begin
          state_d = DRAIN;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      DRAIN: begin
        cnt_d = '0;
        if (xfer) begin
          if (lastRow) begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = '0;
      end
    endcase

    // Start wins over everything except the done pulse of a coinciding final transfer.
    if (I_START_FLAG) begin
      state_d = CAPTURE;
      cnt_d   = CW'(1);
      ptr_d   = '0;
    end
  end

  always_comb begin
    rowIf.O_ROW     = '0;
    rowIf.O_ROW_IDX = '0;
    rowIf.O_LAST    = 1'b0;
    rowIf.O_ROW_VLD = 1'b0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < NCOL; c++) begin
        rowIf.O_ROW[c*8 +: 8] = rowBuf_q[ptr_q][c];
      end
      rowIf.O_ROW_IDX = ptr_q;
      rowIf.O_LAST    = lastRow;
      rowIf.O_ROW_VLD = 1'b1;
    end
  end

  assign O_BUSY = (state_q != IDLE);
  assign O_DONE = done_q;

endmodule

// File: tb/tb_sa_out_deskew_8bit.sv
// Directed bench for sa_out_deskew_8bit: a 4-row/LAT=66 instance and a
// 1-row/LAT=1 instance driven by a skewed-bus model of the systolic array.
module tb_sa_out_deskew_8bit;

  localparam int XR_A  = 4;
  localparam int LAT_A = 66;
  localparam int XR_B  = 1;
  localparam int LAT_B = 1;

  logic         clk;
  logic         rst_n;
  logic         startA, startB;
  logic         rdyA, rdyB;
  logic [511:0] saA, saB;
  logic         busyA, doneA, busyB, doneB;

  int           cyc;
  int           startCycA, startCycB;
  logic [7:0]   xorA, xorB;
  int           numChecks;
  int           numFails;

  sa_out_deskew_8bit_if #(.IDX_W(2)) ifA ();
  sa_out_deskew_8bit_if #(.IDX_W(1)) ifB ();

  assign ifA.I_ROW_RDY = rdyA;
  assign ifB.I_ROW_RDY = rdyB;

  sa_out_deskew_8bit #(.X_R(XR_A), .LAT(LAT_A)) dutA (
    .I_CLK        (clk),
    .I_RST_N      (rst_n),
    .I_START_FLAG (startA),
    .I_SA_OUT     (saA),
    .rowIf        (ifA),
    .O_BUSY       (busyA),
    .O_DONE       (doneA)
  );

  sa_out_deskew_8bit #(.X_R(XR_B), .LAT(LAT_B)) dutB (
    .I_CLK        (clk),
    .I_RST_N      (rst_n),
    .I_START_FLAG (startB),
    .I_SA_OUT     (saB),
    .rowIf        (ifB),
    .O_BUSY       (busyB),
    .O_DONE       (doneB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Skewed SA bus: byte c carries row r = t-lat-c inside its window, 0xFF elsewhere.
  function automatic logic [511:0] saVec(input int t, input int lat, input int xr,
                                         input logic [7:0] x);
    logic [511:0] v;
    int r;
    v = '1;
    for (int c = 0; c < 64; c++) begin
      r = t - lat - c;
      if (r >= 0 && r < xr) v[c*8 +: 8] = 8'(r*16 + c) ^ x;
    end
    return v;
  endfunction

  function automatic logic [511:0] rowExp(input int r, input logic [7:0] x);
    logic [511:0] v;
    for (int c = 0; c < 64; c++) v[c*8 +: 8] = 8'(r*16 + c) ^ x;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs,
                             input logic [511:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic stA, input logic [7:0] xA,
                               input logic stB, input logic [7:0] xB);
    @(posedge clk);
    #1;
    cyc++;
    startA = stA;
    startB = stB;
    if (stA) begin
      startCycA = cyc;
      xorA      = xA;
    end
    if (stB) begin
      startCycB = cyc;
      xorB      = xB;
    end
    saA = saVec(cyc - startCycA, LAT_A, XR_A, xorA);
    saB = saVec(cyc - startCycB, LAT_B, XR_B, xorB);
  endtask

  task automatic advanceTo(input bit useB, input int tgt);
    if (useB) begin
      while (cyc - startCycB < tgt) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    end else begin
      while (cyc - startCycA < tgt) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    end
  endtask

  task automatic checkRowsA(input string tag, input logic [7:0] x);
    for (int r = 0; r < XR_A; r++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput($sformatf("%s_vld%0d", tag, r), ifA.O_ROW_VLD, 1);
      checkOutput($sformatf("%s_idx%0d", tag, r), ifA.O_ROW_IDX, r);
      checkOutput($sformatf("%s_row%0d", tag, r), ifA.O_ROW, rowExp(r, x));
      checkOutput($sformatf("%s_last%0d", tag, r), ifA.O_LAST, (r == XR_A-1));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput({tag, "_done"}, doneA, 1);
    checkOutput({tag, "_vldOff"}, ifA.O_ROW_VLD, 0);
    checkOutput({tag, "_idle"}, busyA, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput({tag, "_doneOnce"}, doneA, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic   bpRdy [4];
    int     expIdx;
    logic   vldSeen, doneSeen, busySeen;

    bpRdy     = '{1'b1, 1'b0, 1'b0, 1'b1};
    numChecks = 0;
    numFails  = 0;
    cyc       = 0;
    startCycA = -100000;
    startCycB = -100000;
    xorA      = 8'h00;
    xorB      = 8'h00;
    rst_n     = 1'b0;
    startA    = 1'b0;
    startB    = 1'b0;
    rdyA      = 1'b0;
    rdyB      = 1'b0;
    saA       = '1;
    saB       = '1;

    #12;
    checkOutput("rstVld",  ifA.O_ROW_VLD, 0);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    checkOutput("rstRow",  ifA.O_ROW, 0);
    checkOutput("rstIdx",  ifA.O_ROW_IDX, 0);
    checkOutput("rstLast", ifA.O_LAST, 0);
    checkOutput("rstVldB", ifB.O_ROW_VLD, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] functional run, ready held high");
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
    rdyA = 1'b1;
    @(negedge clk);
    checkOutput("f_t0Busy", busyA, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("f_t1Busy", busyA, 1);
    checkOutput("f_t1Vld", ifA.O_ROW_VLD, 0);
    advanceTo(1'b0, 132);
    @(negedge clk);
    checkOutput("f_t132Vld", ifA.O_ROW_VLD, 0);
    checkOutput("f_t132Busy", busyA, 1);
    checkRowsA("f", 8'h00);

    $display("[TB] back-pressure run");
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
    rdyA = 1'b0;
    advanceTo(1'b0, 132);
    expIdx = 0;
    for (int k = 0; k < 40 && expIdx < XR_A; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      rdyA = bpRdy[k % 4];
      @(negedge clk);
      checkOutput($sformatf("bp_vld%0d", k), ifA.O_ROW_VLD, 1);
      checkOutput($sformatf("bp_idx%0d", k), ifA.O_ROW_IDX, expIdx);
      checkOutput($sformatf("bp_row%0d", k), ifA.O_ROW, rowExp(expIdx, 8'h00));
      checkOutput($sformatf("bp_last%0d", k), ifA.O_LAST, (expIdx == XR_A-1));
      if (rdyA) expIdx++;
    end
    checkOutput("bp_count", expIdx, XR_A);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    rdyA = 1'b1;
    @(negedge clk);
    checkOutput("bp_done", doneA, 1);
    checkOutput("bp_vldOff", ifA.O_ROW_VLD, 0);

    $display("[TB] abort run, restart at t=80 with xor 0x55");
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
    advanceTo(1'b0, 79);
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    vldSeen  = 1'b0;
    doneSeen = 1'b0;
    for (int k = 0; k < 200 && (cyc - startCycA) < 132; k++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      vldSeen  = vldSeen | ifA.O_ROW_VLD;
      doneSeen = doneSeen | doneA;
    end
    checkOutput("ab_noVld", vldSeen, 0);
    checkOutput("ab_noDone", doneSeen, 0);
    checkOutput("ab_busy", busyA, 1);
    checkRowsA("ab", 8'h55);

    $display("[TB] reset while row 1 is presented");
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
    rdyA = 1'b0;
    advanceTo(1'b0, 132);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    rdyA = 1'b1;
    @(negedge clk);
    checkOutput("rs_idx0", ifA.O_ROW_IDX, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    rdyA = 1'b0;
    @(negedge clk);
    checkOutput("rs_vld1", ifA.O_ROW_VLD, 1);
    checkOutput("rs_idx1", ifA.O_ROW_IDX, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_asyncVld",  ifA.O_ROW_VLD, 0);
    checkOutput("rs_asyncRow",  ifA.O_ROW, 0);
    checkOutput("rs_asyncIdx",  ifA.O_ROW_IDX, 0);
    checkOutput("rs_asyncBusy", busyA, 0);
    checkOutput("rs_asyncLast", ifA.O_LAST, 0);
    repeat (2) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rdyA  = 1'b1;
    vldSeen  = 1'b0;
    busySeen = 1'b0;
    repeat (20) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      @(negedge clk);
      vldSeen  = vldSeen | ifA.O_ROW_VLD;
      busySeen = busySeen | busyA;
    end
    checkOutput("rs_noVldAfter", vldSeen, 0);
    checkOutput("rs_noBusyAfter", busySeen, 0);

    $display("[TB] single-row instance");
    rdyB = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00);
    advanceTo(1'b1, 64);
    @(negedge clk);
    checkOutput("b_t64Vld", ifB.O_ROW_VLD, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("b_vld",  ifB.O_ROW_VLD, 1);
    checkOutput("b_idx",  ifB.O_ROW_IDX, 0);
    checkOutput("b_last", ifB.O_LAST, 1);
    checkOutput("b_row",  ifB.O_ROW, rowExp(0, 8'h00));
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("b_done", doneB, 1);
    checkOutput("b_vldOff", ifB.O_ROW_VLD, 0);

    $display("[TB] start coinciding with the final transfer");
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h00);
    rdyB = 1'b0;
    advanceTo(1'b1, 65);
    @(negedge clk);
    checkOutput("bc_vld", ifB.O_ROW_VLD, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("bc_holdVld", ifB.O_ROW_VLD, 1);
    checkOutput("bc_holdRow", ifB.O_ROW, rowExp(0, 8'h00));
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hA5);
    rdyB = 1'b1;
    @(negedge clk);
    checkOutput("bc_xferVld", ifB.O_ROW_VLD, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("bc_done", doneB, 1);
    checkOutput("bc_busy", busyB, 1);
    checkOutput("bc_vldOff", ifB.O_ROW_VLD, 0);
    advanceTo(1'b1, 65);
    @(negedge clk);
    checkOutput("bc_newVld",  ifB.O_ROW_VLD, 1);
    checkOutput("bc_newRow",  ifB.O_ROW, rowExp(0, 8'hA5));
    checkOutput("bc_newLast", ifB.O_LAST, 1);
    checkOutput("bc_newIdx",  ifB.O_ROW_IDX, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("bc_newDone", doneB, 1);
    checkOutput("bc_newIdle", busyB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
